// File: rtl/tx_engine_if.sv
// tx_engine_if -- host-side bus of the serial transmit engine.
//   load       host write strobe, one cycle
//   load_data  character to send, valid with load
//   bit10_9    frame bits 10:9 from the parity/eighth-bit decoder, valid with load
//   k          clocks per bit time, static during a frame
//   tx         serial line, idle high
//   txrdy      engine can accept a new load
//   line_break force the line low (present only with TX_BREAK_EN)
// Modports: master = host side, slave = engine side.
interface tx_engine_if #(
  parameter int BAUD_W = 19
);
  logic              load;
  logic [7:0]        load_data;
  logic [1:0]        bit10_9;
  logic [BAUD_W-1:0] k;
  logic              tx;
  logic              txrdy;
`ifdef TX_BREAK_EN
  logic              line_break;
`endif

`ifdef TX_BREAK_EN
  modport master (output load, load_data, bit10_9, k, line_break, input tx, txrdy);
  modport slave  (input load, load_data, bit10_9, k, line_break, output tx, txrdy);
`else
  modport master (output load, load_data, bit10_9, k, input tx, txrdy);
  modport slave  (input load, load_data, bit10_9, k, output tx, txrdy);
`endif
endinterface

// File: rtl/tx_engine.sv
// tx_engine -- 11-bit serial frame transmitter with programmable bit time.
// Frame order on tx: pad 1, start 0, load_data[0..6], bit10_9[0], bit10_9[1],
// each bit lasting max(k,1) clocks.
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      tx_engine_if.slave (load, load_data, bit10_9, k, tx, txrdy)
// Optional feature: define TX_BREAK_EN to add bus.line_break, which forces
// tx and txrdy low (registered) without disturbing the frame counters.
//
// state  | meaning
// S_IDLE | no frame in flight, shift register all ones, txrdy high
// S_SEND | frame shifting out, one shift per bit-time tick
module tx_engine #(
  parameter int BAUD_W = 19
) (
  input logic        clk,
  input logic        reset_n,
  tx_engine_if.slave bus
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t            state, state_next;
  logic [10:0]       sr, sr_next;
  logic [BAUD_W-1:0] btc, btc_next;
  logic [3:0]        bc, bc_next;
  logic              tx_q;
  logic              txrdy_q;
  logic [BAUD_W-1:0] keff_m1;
  logic              btu;
  logic              accept;
  logic              unused_data7;

  assign unused_data7 = bus.load_data[7];

  // k=0 behaves as k=1, so the terminal count never underflows.
  assign keff_m1 = (bus.k == '0) ? '0 : bus.k - BAUD_W'(1);
  assign btu     = (state == S_SEND) && (btc == keff_m1);
  assign accept  = bus.load && txrdy_q;

  always_comb begin
    state_next = state;
    sr_next    = sr;
    btc_next   = btc;
    bc_next    = bc;
    case (state)
      S_IDLE: begin
        sr_next  = 11'h7FF;
        btc_next = '0;
        bc_next  = '0;
        if (accept) begin
          sr_next    = {bus.bit10_9[1], bus.bit10_9[0], bus.load_data[6:0], 1'b0, 1'b1};
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (btu) begin
          sr_next  = {1'b1, sr[10:1]};
          btc_next = '0;
          if (bc == 4'd10) begin
            bc_next    = '0;
            state_next = S_IDLE;
          end else begin
            bc_next = bc + 4'd1;
          end
        end else begin
          btc_next = btc + BAUD_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      sr      <= 11'h7FF;
      btc     <= '0;
      bc      <= '0;
      tx_q    <= 1'b1;
      txrdy_q <= 1'b1;
    end else begin
      state <= state_next;
      sr    <= sr_next;
      btc   <= btc_next;
      bc    <= bc_next;
`ifdef TX_BREAK_EN
      tx_q    <= bus.line_break ? 1'b0 : sr_next[0];
      txrdy_q <= (state_next == S_IDLE) && !bus.line_break;
`else
      // tx tracks sr[0] exactly; both update on the same edge.
      tx_q    <= sr_next[0];
      txrdy_q <= (state_next == S_IDLE);
`endif
    end
  end

  assign bus.tx    = tx_q;
  assign bus.txrdy = txrdy_q;

endmodule
